// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared APU width constants plus the types used by the cluster APU arbiter.
package cv32e40p_apu_core_pkg;

    localparam int APU_NARGS_CPU     = 3;
    localparam int APU_WOP_CPU       = 6;
    localparam int APU_NDSFLAGS_CPU  = 15;
    localparam int APU_NUSFLAGS_CPU  = 5;

    localparam int APU_ARB_MAX_CORES = 16;

    typedef enum logic {
        IDLE,
        LOCKED
    } apu_arb_state_e;

endpackage

// File: rtl/cv32e40p_apu_arb_id_fifo.sv
// In-order FIFO of requester IDs; each entry names the core that owns the
// next APU response. Pushes while full and pops while empty are ignored.
module cv32e40p_apu_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_data   = r_mem[r_rdPtr];

    // Storage, pointers and occupancy; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one APU between NB_CORES cores; responses are
// routed back in order through an ID FIFO.
// Optional macro CV32E40P_APU_ARB_PERF_EN adds a saturating contention counter.
module cv32e40p_apu_arbiter
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int NB_CORES        = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int IDW             = $clog2(NB_CORES)
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic [NB_CORES-1:0]                               core_apu_req_i,
    output logic [NB_CORES-1:0]                               core_apu_gnt_o,
    input  logic [NB_CORES-1:0][APU_NARGS_CPU-1:0][31:0]      core_apu_operands_i,
    input  logic [NB_CORES-1:0][APU_WOP_CPU-1:0]              core_apu_op_i,
    input  logic [NB_CORES-1:0][APU_NDSFLAGS_CPU-1:0]         core_apu_flags_i,
    output logic [NB_CORES-1:0]                               core_apu_rvalid_o,
    output logic [31:0]                                       core_apu_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                       core_apu_flags_o,
    output logic                                              apu_req_o,
    input  logic                                              apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]                    apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                            apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]                       apu_flags_o,
    input  logic                                              apu_rvalid_i,
    input  logic [31:0]                                       apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                       apu_flags_i,
    output logic [$clog2(MAX_OUTSTANDING):0]                  outstanding_o,
    output logic                                              rsp_err_o
`ifdef CV32E40P_APU_ARB_PERF_EN
    ,
    output logic [31:0]                                       contention_cnt_o
`endif
);

    apu_arb_state_e r_state;
    apu_arb_state_e w_nextState;
    logic [IDW-1:0] r_lockId;
    logic [IDW-1:0] r_rrPtr;
    logic           r_rspErr;
    logic [IDW-1:0] w_rrWinner;
    logic [IDW-1:0] w_winner;
    logic [IDW-1:0] w_head;
    logic           w_anyReq;
    logic           w_apuReq;
    logic           w_handshake;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;

    assign w_handshake       = w_apuReq & apu_gnt_i;
    assign w_pop             = apu_rvalid_i & ~w_empty;
    assign rsp_err_o         = r_rspErr;
    assign core_apu_result_o = apu_result_i;
    assign core_apu_flags_o  = apu_flags_i;

    // Round-robin pick: first requesting core at or after r_rrPtr, cyclically
    always_comb begin
        int idx;
        idx        = 0;
        w_anyReq   = 1'b0;
        w_rrWinner = r_rrPtr;
        for (int i = 0; i < NB_CORES; i++) begin
            idx = int'(r_rrPtr) + i;
            if (idx >= NB_CORES) begin
                idx = idx - NB_CORES;
            end
            if (!w_anyReq && core_apu_req_i[IDW'(idx)]) begin
                w_anyReq   = 1'b1;
                w_rrWinner = IDW'(idx);
            end
        end
    end

    // Next-state logic; LOCKED pins the winner so the payload cannot change
    // under a stalled request, and a full ID FIFO blocks new requests
    always_comb begin
        w_nextState = r_state;
        w_apuReq    = 1'b0;
        w_winner    = w_rrWinner;
        if (!rst_i) begin
            case (r_state)
                IDLE: begin
                    if (!w_full && w_anyReq) begin
                        w_apuReq = 1'b1;
                        if (!apu_gnt_i) begin
                            w_nextState = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    w_apuReq = 1'b1;
                    w_winner = r_lockId;
                    if (apu_gnt_i) begin
                        w_nextState = IDLE;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    // State, lock id, round-robin pointer and sticky orphan-response flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_lockId <= '0;
            r_rrPtr  <= '0;
            r_rspErr <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && w_nextState == LOCKED) begin
                r_lockId <= w_winner;
            end
            if (w_handshake) begin
                r_rrPtr <= (w_winner == IDW'(NB_CORES - 1)) ? '0 : w_winner + 1'b1;
            end
            if (apu_rvalid_i && w_empty) begin
                r_rspErr <= 1'b1;
            end
        end
    end

    // Payload mux, grant decode and response routing to the FIFO head core
    always_comb begin
        apu_req_o         = w_apuReq;
        apu_operands_o    = '0;
        apu_op_o          = '0;
        apu_flags_o       = '0;
        core_apu_gnt_o    = '0;
        core_apu_rvalid_o = '0;
        if (w_apuReq) begin
            apu_operands_o           = core_apu_operands_i[w_winner];
            apu_op_o                 = core_apu_op_i[w_winner];
            apu_flags_o              = core_apu_flags_i[w_winner];
            core_apu_gnt_o[w_winner] = apu_gnt_i;
        end
        if (w_pop) begin
            core_apu_rvalid_o[w_head] = 1'b1;
        end
    end

    cv32e40p_apu_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDW)
    ) u_idFifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_handshake),
        .i_data  (w_winner),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (outstanding_o)
    );

`ifdef CV32E40P_APU_ARB_PERF_EN
    logic [31:0]         r_contentionCnt;
    logic [NB_CORES-1:0] w_others;

    // Requests from cores other than the current winner
    always_comb begin
        w_others           = core_apu_req_i;
        w_others[w_winner] = 1'b0;
    end

    // Saturating count of cycles where another core waits behind the winner
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_contentionCnt <= '0;
        end else if (w_apuReq && (|w_others) && (r_contentionCnt != '1)) begin
            r_contentionCnt <= r_contentionCnt + 1'b1;
        end
    end

    assign contention_cnt_o = r_contentionCnt;
`endif

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed bench for the APU arbiter: round-robin order, lock stability,
// FIFO-full blocking, orphan responses and asynchronous reset.
module tb_cv32e40p_apu_arbiter;
    import cv32e40p_apu_core_pkg::*;

    localparam int NB = 4;
    localparam int MO = 4;

    logic                                         clk;
    logic                                         rst;
    logic [NB-1:0]                                coreReq;
    logic [NB-1:0]                                coreGnt;
    logic [NB-1:0][APU_NARGS_CPU-1:0][31:0]       coreOperands;
    logic [NB-1:0][APU_WOP_CPU-1:0]               coreOp;
    logic [NB-1:0][APU_NDSFLAGS_CPU-1:0]          coreFlags;
    logic [NB-1:0]                                coreRvalid;
    logic [31:0]                                  coreResult;
    logic [APU_NUSFLAGS_CPU-1:0]                  coreRspFlags;
    logic                                         apuReq;
    logic                                         apuGnt;
    logic [APU_NARGS_CPU-1:0][31:0]               apuOperands;
    logic [APU_WOP_CPU-1:0]                       apuOp;
    logic [APU_NDSFLAGS_CPU-1:0]                  apuFlags;
    logic                                         apuRvalid;
    logic [31:0]                                  apuResult;
    logic [APU_NUSFLAGS_CPU-1:0]                  apuRspFlags;
    logic [$clog2(MO):0]                          outstanding;
    logic                                         rspErr;
`ifdef CV32E40P_APU_ARB_PERF_EN
    logic [31:0]                                  contentionCnt;
`endif

    int nAssert;
    int nFail;

    cv32e40p_apu_arbiter #(
        .NB_CORES        (NB),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .core_apu_req_i      (coreReq),
        .core_apu_gnt_o      (coreGnt),
        .core_apu_operands_i (coreOperands),
        .core_apu_op_i       (coreOp),
        .core_apu_flags_i    (coreFlags),
        .core_apu_rvalid_o   (coreRvalid),
        .core_apu_result_o   (coreResult),
        .core_apu_flags_o    (coreRspFlags),
        .apu_req_o           (apuReq),
        .apu_gnt_i           (apuGnt),
        .apu_operands_o      (apuOperands),
        .apu_op_o            (apuOp),
        .apu_flags_o         (apuFlags),
        .apu_rvalid_i        (apuRvalid),
        .apu_result_i        (apuResult),
        .apu_flags_i         (apuRspFlags),
        .outstanding_o       (outstanding),
        .rsp_err_o           (rspErr)
`ifdef CV32E40P_APU_ARB_PERF_EN
        ,
        .contention_cnt_o    (contentionCnt)
`endif
    );

    // 10 ns clock; stimulus changes on the falling edge
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [NB-1:0] req, input logic gnt, input logic rvalid);
        coreReq   = req;
        apuGnt    = gnt;
        apuRvalid = rvalid;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAssert++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Directed sequence; inputs change after negedge, outputs sampled 1 ns later
    initial begin
        nAssert = 0;
        nFail   = 0;
        for (int i = 0; i < NB; i++) begin
            coreOp[i]    = APU_WOP_CPU'(10 + i);
            coreFlags[i] = APU_NDSFLAGS_CPU'(5 + i);
            for (int j = 0; j < APU_NARGS_CPU; j++) begin
                coreOperands[i][j] = 32'hA000_0000 + 32'(i * 16 + j);
            end
        end
        apuResult   = 32'h1234_5678;
        apuRspFlags = 5'h15;
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_req",         32'(apuReq),      32'h0);
        checkOutput("rst_gnt",         32'(coreGnt),     32'h0);
        checkOutput("rst_rvalid",      32'(coreRvalid),  32'h0);
        checkOutput("rst_outstanding", 32'(outstanding), 32'h0);
        checkOutput("rst_rsp_err",     32'(rspErr),      32'h0);
        checkOutput("rst_op",          32'(apuOp),       32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Round-robin: cores 1 and 3, APU always grants
        applyStimulus(4'b1010, 1'b1, 1'b0); #1;
        checkOutput("t1_req",  32'(apuReq),         32'h1);
        checkOutput("t1_gnt1", 32'(coreGnt),        32'b0010);
        checkOutput("t1_op1",  32'(apuOp),          32'd11);
        checkOutput("t1_opnd", apuOperands[1],      32'hA000_0011);
        @(negedge clk);
        applyStimulus(4'b1000, 1'b1, 1'b0); #1;
        checkOutput("t1_gnt3",  32'(coreGnt),       32'b1000);
        checkOutput("t1_flag3", 32'(apuFlags),      32'd8);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 1'b1); #1;
        checkOutput("t1_out2",   32'(outstanding),  32'd2);
        checkOutput("t1_rv1",    32'(coreRvalid),   32'b0010);
        checkOutput("t1_result", coreResult,        32'h1234_5678);
        checkOutput("t1_rflags", 32'(coreRspFlags), 32'h15);
        checkOutput("t1_idle",   32'(apuReq),       32'h0);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 1'b1); #1;
        checkOutput("t1_rv3", 32'(coreRvalid), 32'b1000);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 1'b0); #1;
        checkOutput("t1_out0", 32'(outstanding), 32'd0);

        // Lock: core 2 stalls three cycles while core 0 joins (rr_ptr = 0)
        @(negedge clk);
        applyStimulus(4'b0100, 1'b0, 1'b0); #1;
        checkOutput("t2_op_c1", 32'(apuOp),   32'd12);
        checkOutput("t2_ngnt",  32'(coreGnt), 32'h0);
        @(negedge clk);
        applyStimulus(4'b0101, 1'b0, 1'b0); #1;
        checkOutput("t2_op_c2", 32'(apuOp),   32'd12);
        checkOutput("t2_req",   32'(apuReq),  32'h1);
        @(negedge clk);
        applyStimulus(4'b0101, 1'b0, 1'b0); #1;
        checkOutput("t2_op_c3", 32'(apuOp),   32'd12);
        @(negedge clk);
        applyStimulus(4'b0101, 1'b1, 1'b0); #1;
        checkOutput("t2_gnt2",  32'(coreGnt), 32'b0100);
        checkOutput("t2_op_c4", 32'(apuOp),   32'd12);
        @(negedge clk);
        applyStimulus(4'b0001, 1'b1, 1'b0); #1;
        checkOutput("t2_gnt0",  32'(coreGnt), 32'b0001);
        checkOutput("t2_op0",   32'(apuOp),   32'd10);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 1'b1); #1;
        checkOutput("t2_rv2", 32'(coreRvalid), 32'b0100);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 1'b1); #1;
        checkOutput("t2_rv0", 32'(coreRvalid), 32'b0001);

        // FIFO full: four grants from rr_ptr = 1, then blocked
        @(negedge clk);
        applyStimulus(4'b1111, 1'b1, 1'b0); #1;
        checkOutput("t3_gnt_a", 32'(coreGnt), 32'b0010);
        @(negedge clk);
        applyStimulus(4'b1111, 1'b1, 1'b0); #1;
        checkOutput("t3_gnt_b", 32'(coreGnt), 32'b0100);
        @(negedge clk);
        applyStimulus(4'b1111, 1'b1, 1'b0); #1;
        checkOutput("t3_gnt_c", 32'(coreGnt), 32'b1000);
        @(negedge clk);
        applyStimulus(4'b1111, 1'b1, 1'b0); #1;
        checkOutput("t3_gnt_d", 32'(coreGnt), 32'b0001);
        @(negedge clk);
        applyStimulus(4'b1111, 1'b1, 1'b0); #1;
        checkOutput("t3_out4",     32'(outstanding), 32'd4);
        checkOutput("t3_full_req", 32'(apuReq),      32'h0);
        checkOutput("t3_full_gnt", 32'(coreGnt),     32'h0);
        @(negedge clk);
        applyStimulus(4'b1111, 1'b1, 1'b1); #1;
        checkOutput("t3_nobypass", 32'(apuReq),      32'h0);
        checkOutput("t3_rv1",      32'(coreRvalid),  32'b0010);
        @(negedge clk);
        applyStimulus(4'b1111, 1'b1, 1'b0); #1;
        checkOutput("t3_out3",  32'(outstanding), 32'd3);
        checkOutput("t3_regnt", 32'(coreGnt),     32'b0010);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 1'b1); #1;
        checkOutput("t3_drain2", 32'(coreRvalid), 32'b0100);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 1'b1); #1;
        checkOutput("t3_drain3", 32'(coreRvalid), 32'b1000);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 1'b1); #1;
        checkOutput("t3_drain0", 32'(coreRvalid), 32'b0001);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 1'b1); #1;
        checkOutput("t3_drain1", 32'(coreRvalid), 32'b0010);

        // Orphan response with the FIFO empty
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 1'b1); #1;
        checkOutput("t4_rv0",  32'(coreRvalid), 32'h0);
        checkOutput("t4_err0", 32'(rspErr),     32'h0);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 1'b0); #1;
        checkOutput("t4_err1", 32'(rspErr), 32'h1);
        @(negedge clk); #1;
        checkOutput("t4_sticky", 32'(rspErr), 32'h1);

        // Async reset while LOCKED with two outstanding (rr_ptr = 2 here)
        @(negedge clk);
        applyStimulus(4'b1000, 1'b1, 1'b0); #1;
        checkOutput("t5_gnt3", 32'(coreGnt), 32'b1000);
        @(negedge clk);
        applyStimulus(4'b0001, 1'b1, 1'b0); #1;
        checkOutput("t5_gnt0", 32'(coreGnt), 32'b0001);
        @(negedge clk);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        @(negedge clk); #1;
        checkOutput("t5_locked_op", 32'(apuOp),       32'd13);
        checkOutput("t5_out2",      32'(outstanding), 32'd2);
        rst = 1'b1; #1;
        checkOutput("t5_rst_req", 32'(apuReq),      32'h0);
        checkOutput("t5_rst_op",  32'(apuOp),       32'h0);
        checkOutput("t5_rst_out", 32'(outstanding), 32'd0);
        checkOutput("t5_rst_err", 32'(rspErr),      32'h0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(4'b0011, 1'b1, 1'b0); #1;
        checkOutput("t5_first_gnt", 32'(coreGnt), 32'b0001);
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 1'b0);

`ifdef CV32E40P_APU_ARB_PERF_EN
        // Contention: all cores request, APU grants every other cycle
        rst = 1'b1;
        @(negedge clk); #1;
        checkOutput("t6_cnt_rst", contentionCnt, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            applyStimulus(4'b1111, 1'(k % 2), 1'b0);
        end
        @(negedge clk);
        applyStimulus(4'b0000, 1'b0, 1'b0); #1;
        checkOutput("t6_cnt", contentionCnt, 32'd8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/cv32e40p_apu_arbiter.md
Name: cv32e40p_apu_arbiter

Overview:
Shares one APU/FPU instance between NB_CORES cv32e40p cores in a PULP cluster. Performs round-robin arbitration of the per-core apu_req/apu_gnt request channels. Records each granted requester in an in-order ID FIFO, so that every apu_rvalid response is routed back to the core that issued the operation. Sits between the core APU ports and the shared APU; the APU must return results in order.

Parameters:
NB_CORES, 4, number of requesting cores (2..16)
MAX_OUTSTANDING, 4, ID FIFO depth, i.e. maximum APU operations in flight (power of 2, >=2)
IDW, $clog2(NB_CORES), width of the requester ID

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
core_apu_req_i  in  NB_CORES  per-core request
core_apu_gnt_o  out  NB_CORES  per-core grant
core_apu_operands_i  in  NB_CORES x APU_NARGS_CPU x 32  per-core operands
core_apu_op_i  in  NB_CORES x APU_WOP_CPU  per-core opcode
core_apu_flags_i  in  NB_CORES x APU_NDSFLAGS_CPU  per-core request flags
core_apu_rvalid_o  out  NB_CORES  per-core response valid (one-hot or zero)
core_apu_result_o  out  32  broadcast result
core_apu_flags_o  out  APU_NUSFLAGS_CPU  broadcast response flags
apu_req_o  out  1  request to shared APU
apu_gnt_i  in  1  APU grant
apu_operands_o  out  APU_NARGS_CPU x 32  muxed operands
apu_op_o  out  APU_WOP_CPU  muxed opcode
apu_flags_o  out  APU_NDSFLAGS_CPU  muxed flags
apu_rvalid_i  in  1  APU response valid
apu_result_i  in  32  APU result
apu_flags_i  in  APU_NUSFLAGS_CPU  APU response flags
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy
rsp_err_o  out  1  sticky: apu_rvalid_i received with the FIFO empty

Behaviour:
- Reset (asynchronous): FSM=IDLE, rr_ptr=0, FIFO empty, outstanding_o=0, rsp_err_o=0. All gnt/rvalid/req outputs are 0. Payload outputs are 0 while apu_req_o=0.
- FSM has two states, IDLE and LOCKED.
  - IDLE: if the FIFO is not full and any request is set, select winner w = first set requester at or after rr_ptr, cyclically. Drive apu_req_o=1 and the payload from w in the same cycle (combinational).
    - If apu_gnt_i=1 in that cycle: handshake, stay in IDLE.
    - Otherwise: register w into lock_id and go to LOCKED.
  - LOCKED: winner is lock_id regardless of other requests, so the payload stays stable. apu_req_o=1. On apu_gnt_i, return to IDLE.
- core_apu_gnt_o[w] = apu_req_o & apu_gnt_i. All other grant bits are 0.
- Handshake: push w into the FIFO and set rr_ptr = (w+1) mod NB_CORES, with wrap at NB_CORES-1 -> 0.
- FIFO full: apu_req_o=0 and no grant. A pop in the same cycle does not unblock the request (no bypass); the request can be issued from the next cycle.
- Response: when apu_rvalid_i=1 and the FIFO is non-empty, core_apu_rvalid_o[head]=1 in the same cycle (combinational, 0 latency) and the FIFO pops. result/flags pass through unregistered.
- apu_rvalid_i with the FIFO empty: drop the response, keep all core_apu_rvalid_o=0, set rsp_err_o=1 until reset.
- Simultaneous push and pop with the FIFO non-full: occupancy is unchanged and ordering is preserved.
- The requesting core dropping its req while LOCKED is a protocol violation (cores hold req until gnt). There is no recovery: the arbiter stays LOCKED on that core.

Optional Feature:
CV32E40P_APU_ARB_PERF_EN
- Defined: adds output contention_cnt_o (32 bits, reset 0). It increments once per cycle in which apu_req_o=1 and at least one other core's req is set but not granted. It saturates at 0xFFFFFFFF.
- Undefined: the port and the counter are absent.

Decomposition:
- cv32e40p_apu_core_pkg: add APU_ARB_MAX_CORES=16 and typedef apu_arb_state_e {IDLE, LOCKED}.
- Keep using its existing APU_* width constants.
- One sub-module: cv32e40p_apu_arb_id_fifo. It is a synchronous FIFO of IDW-bit entries, depth MAX_OUTSTANDING, with full/empty/count outputs and asynchronous active-high reset.
- The round-robin pick is combinational logic in the top module.

Test Plan:
1. NB_CORES=4, rr_ptr=0. Cores 1 and 3 request and apu_gnt_i=1 every cycle -> grants go to core 1, then core 3. Routed apu_rvalid_i pulses assert core_apu_rvalid_o=4'b0010, then 4'b1000.
2. Core 2 requests with apu_gnt_i held 0 for 3 cycles while core 0 raises its request -> the FSM stays LOCKED and apu_op_o stays equal to core 2's op. Core 2 is granted on the 4th cycle, then core 0 on the next cycle.
3. MAX_OUTSTANDING=4. Issue 4 grants with no rvalid -> outstanding_o=4 and apu_req_o=0 despite pending requests. One rvalid -> the next request is granted one cycle later.
4. apu_rvalid_i=1 with the FIFO empty -> all core_apu_rvalid_o=0 and rsp_err_o=1, persisting until rst_i.
5. Assert rst_i while LOCKED with 2 outstanding operations -> outputs go to 0 immediately (asynchronous reset), outstanding_o=0, and the first grant after release goes to the lowest requesting core at or above 0.
6. With CV32E40P_APU_ARB_PERF_EN defined, all 4 cores request and the APU grants every other cycle for 8 cycles -> contention_cnt_o=8.
